branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating direction counters.
//  F stage looks up pc_f and gets predicted direction/target in the same cycle.
//  The branch comparator in D stage resolves the branch and returns the outcome on the update port.
//  Also keeps resolved-branch and mispredict counters for performance reporting.
// PARAMETERS
//  IDX_BITS   4   index width; ENTRIES = 2**IDX_BITS; index = pc[IDX_BITS+1:2]
//  TAG_BITS   30-IDX_BITS (derived localparam)   tag = pc[31:IDX_BITS+2]
// PORTS
//  clk            in   1    rising-edge clock
//  reset_n        in   1    asynchronous active-low reset
//  pc_f           in   32   fetch PC (word aligned)
//  pred_hit       out  1    tag match on a valid entry for pc_f
//  pred_taken     out  1    pred_hit && counter[1]
//  pred_target    out  32   stored target when pred_taken, else pc_f+4
//  upd_valid      in   1    resolved branch this cycle
//  upd_pc         in   32   PC of resolved branch
//  upd_taken      in   1    branch outcome from comparator
//  upd_target     in   32   computed taken target
//  upd_pred_taken in   1    prediction that travelled with this branch
//  upd_pred_tgt   in   32   predicted target that travelled with this branch
//  mispredict     out  1    combinational: upd_valid && (direction wrong || taken && target wrong)
//  branch_cnt     out  32   number of accepted updates
//  miss_cnt       out  32   number of updates flagged mispredict
// BEHAVIOUR
//  - Storage per entry: valid, tag, ctr[1:0], target[31:0]; all registers, no RAM macro.
//  - Reset (reset_n=0, async): every valid=0, ctr=2'b01, target=0, tag=0; branch_cnt=0, miss_cnt=0.
//    Lookup outputs are therefore pred_hit=0, pred_taken=0, pred_target=pc_f+4 during/after reset.
//  - Lookup is purely combinational from stored state; 0-cycle latency.
//  - Update (upd_valid=1) commits on the next rising edge; idx/tag taken from upd_pc:
//    * hit & taken:      ctr=sat_inc(ctr) (11 stays 11); target=upd_target.
//    * hit & not taken:  ctr=sat_dec(ctr) (00 stays 00); target unchanged.
//    * miss & taken:     allocate/replace: valid=1, tag=new, ctr=2'b10, target=upd_target.
//    * miss & not taken: no table write.
//  - mispredict compares against upd_pred_taken/upd_pred_tgt, not the current table contents.
//    Target mismatch counts only when both predicted and actual are taken.
//  - Counters: branch_cnt+=1 per upd_valid; miss_cnt+=1 when mispredict; both wrap modulo 2**32.
//  - Same-cycle lookup and update of the same index: lookup returns PRE-update state (no bypass);
//    new state visible from the next cycle.
//  - upd_valid=0: no state change whatsoever; mispredict=0.
//  - Reset asserted mid-operation: table and counters clear immediately, regardless of clk;
//    an update in the same cycle as reset release is ignored if reset_n is low at the edge.
//  - pc_f/upd_pc bits [1:0] ignored.
// TESTING
//  1 reset, pc_f=0x00003000 -> pred_hit=0, pred_taken=0, pred_target=0x00003004; counters 0.
//  2 update pc=0x3010 taken tgt=0x3040 pred_taken=0 -> mispredict=1; next cycle lookup 0x3010:
//    hit=1, taken=1 (ctr=10), target=0x3040; branch_cnt=1, miss_cnt=1.
//  3 same pc three not-taken updates -> ctr 10->01->00->00; pred_taken=0 after first; hit stays 1.
//  4 alias: pc 0x3010 entry valid, taken update at 0x3050 (same idx, IDX_BITS=4) -> replaced;
//    lookup 0x3010 -> hit=0; lookup 0x3050 -> hit=1, ctr=10.
//  5 pc_f=upd_pc=0x3010 same cycle, update taken on empty entry -> that cycle hit=0; next cycle hit=1.
//  6 preload miss_cnt near wrap via 2**32 forced value or long run -> wraps to 0; reset_n pulse
//    low between clk edges -> all counters and valid bits 0 before the next edge.

Source files
------------

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - Direct-mapped BTB with 2-bit direction counters and branch/mispredict statistics
module branch_predictor #(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_f,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_tgt,
    output logic        mispredict,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
);
    localparam int ENTRIES  = 2 ** IDX_BITS;
    localparam int TAG_BITS = 30 - IDX_BITS;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [31:0]         branch_cnt_q, branch_cnt_d;
    logic [31:0]         miss_cnt_q, miss_cnt_d;

    logic [IDX_BITS-1:0] f_idx, u_idx;
    logic [TAG_BITS-1:0] f_tag, u_tag;
    logic                u_hit;
    logic [1:0]          u_ctr, u_ctr_d;
    logic                unused_pc_bits;

    assign unused_pc_bits = ^{pc_f[1:0], upd_pc[1:0]};

    assign f_idx = pc_f[IDX_BITS+1:2];
    assign f_tag = pc_f[31:IDX_BITS+2];
    assign u_idx = upd_pc[IDX_BITS+1:2];
    assign u_tag = upd_pc[31:IDX_BITS+2];

    // Lookup reads stored state only, so a same-cycle update is not bypassed.
    assign pred_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken  = pred_hit && ctr_q[f_idx][1];
    assign pred_target = pred_taken ? target_q[f_idx] : pc_f + 32'd4;

    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_ctr = ctr_q[u_idx];

    always_comb begin
        u_ctr_d = u_ctr;
        if (upd_taken) begin
            if (u_ctr != 2'b11) u_ctr_d = u_ctr + 2'd1;
        end else begin
            if (u_ctr != 2'b00) u_ctr_d = u_ctr - 2'd1;
        end
    end

    // Judged against the prediction carried with the branch, not the current table.
    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && upd_pred_taken && (upd_target != upd_pred_tgt)));

    assign branch_cnt_d = branch_cnt_q + {31'd0, upd_valid};
    assign miss_cnt_d   = miss_cnt_q + {31'd0, mispredict};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                ctr_q[i]    <= 2'b01;
                target_q[i] <= 32'd0;
            end
            branch_cnt_q <= 32'd0;
            miss_cnt_q   <= 32'd0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            if (upd_valid) begin
                if (u_hit) begin
                    ctr_q[u_idx] <= u_ctr_d;
                    if (upd_taken) target_q[u_idx] <= upd_target;
                end else if (upd_taken) begin
                    valid_q[u_idx]  <= 1'b1;
                    tag_q[u_idx]    <= u_tag;
                    ctr_q[u_idx]    <= 2'b10;
                    target_q[u_idx] <= upd_target;
                end
            end
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - Directed self-checking bench for branch_predictor
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_f;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc, upd_target, upd_pred_tgt;
    logic        upd_taken, upd_pred_taken;
    logic        mispredict;
    logic [31:0] branch_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_br = 0;
    logic [31:0] exp_miss = 0;

    branch_predictor #(.IDX_BITS(4)) dut (
        .clk(clk), .reset_n(reset_n), .pc_f(pc_f),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_tgt(upd_pred_tgt), .mispredict(mispredict),
        .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic tk, input logic [31:0] tgt);
        pc_f = pc;
        #1;
        chk({tag, ".hit"}, {31'd0, pred_hit}, {31'd0, hit});
        chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, tk});
        chk({tag, ".target"}, pred_target, tgt);
    endtask

    task automatic counts(input string tag);
        chk({tag, ".branch_cnt"}, branch_cnt, exp_br);
        chk({tag, ".miss_cnt"}, miss_cnt, exp_miss);
    endtask

    task automatic upd(input string tag, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                       input logic exp_mis);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        upd_pred_taken = ptk; upd_pred_tgt = ptgt;
        #1;
        chk({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, exp_mis});
        exp_br = exp_br + 1;
        if (exp_mis) exp_miss = exp_miss + 1;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        #1;
    endtask

    initial begin
        reset_n = 1'b0; pc_f = 32'h3000; upd_valid = 1'b0; upd_pc = 0; upd_taken = 0;
        upd_target = 0; upd_pred_taken = 0; upd_pred_tgt = 0;
        look("reset", 32'h3000, 0, 0, 32'h3004);
        counts("reset");
        #11 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle.mispredict", {31'd0, mispredict}, 32'd0);

        // Allocate on a taken miss; same-cycle lookup still sees the empty entry.
        pc_f = 32'h3010;
        #1 chk("same_cycle.hit", {31'd0, pred_hit}, 32'd0);
        upd("alloc", 32'h3010, 1, 32'h3040, 0, 0, 1);
        look("alloc", 32'h3010, 1, 1, 32'h3040);
        counts("alloc");

        // Counter walks down 10->01->00->00 and saturates.
        upd("nt1", 32'h3010, 0, 0, 1, 32'h3040, 1);
        look("nt1", 32'h3010, 1, 0, 32'h3014);
        upd("nt2", 32'h3010, 0, 0, 0, 0, 0);
        upd("nt3", 32'h3010, 0, 0, 0, 0, 0);
        look("nt3", 32'h3010, 1, 0, 32'h3014);
        upd("tk1", 32'h3010, 1, 32'h3080, 0, 0, 1);
        look("tk1", 32'h3010, 1, 0, 32'h3014);
        upd("tk2", 32'h3010, 1, 32'h3088, 0, 0, 1);
        look("tk2", 32'h3010, 1, 1, 32'h3088);
        // Target mismatch with both taken, then saturation at 11.
        upd("tgt_wrong", 32'h3010, 1, 32'h3090, 1, 32'h3088, 1);
        upd("tgt_ok", 32'h3010, 1, 32'h3090, 1, 32'h3090, 0);
        upd("sat_hi", 32'h3010, 0, 0, 1, 32'h3090, 1);
        look("sat_hi", 32'h3010, 1, 1, 32'h3090);
        counts("mid");

        // Alias on the same index replaces the entry.
        upd("alias", 32'h3050, 1, 32'h3200, 0, 0, 1);
        look("alias_old", 32'h3010, 0, 0, 32'h3014);
        look("alias_new", 32'h3050, 1, 1, 32'h3200);
        upd("alias_nt", 32'h3050, 0, 0, 1, 32'h3200, 1);
        look("alias_nt", 32'h3050, 1, 0, 32'h3054);

        // Not-taken miss writes nothing; ignored low pc bits.
        upd("miss_nt", 32'h3020, 0, 0, 0, 0, 0);
        look("miss_nt", 32'h3020, 0, 0, 32'h3024);
        look("lowbits", 32'h3053, 1, 0, 32'h3057);
        counts("pre_reset");

        // Async reset between edges, with an update held across the edge.
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        counts_zero();
        look("async_rst", 32'h3050, 0, 0, 32'h3054);
        upd_valid = 1'b1; upd_pc = 32'h3010; upd_taken = 1; upd_target = 32'h3040;
        upd_pred_taken = 0;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        look("rst_upd_ignored", 32'h3010, 0, 0, 32'h3014);
        counts_zero();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic counts_zero();
        exp_br = 0; exp_miss = 0;
        counts("rst");
    endtask

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout observed running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end
endmodule
